gb_cpu_instr_assembler: RTL
===========================

# gb_cpu_instr_assembler

Prefetching instruction-byte queue and operand assembler between the bus interface and the decoder. It fetches sequential bytes into a parametrised FIFO and assembles complete instructions (opcode, CB flag, 8/16-bit immediate) using the decoder's state sequence. It emits one bundle per valid/ready handshake. On a PC redirect it flushes everything and restarts fetch at the new address.

## Interface
- QUEUE_DEPTH, 4: byte FIFO entries; power of two, ≥2.
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset, synchronous, active-low.
- flush_i  in  1  redirect: discard queue, assembler and in-flight byte.
- redirect_pc_i  in  16  new fetch PC, sampled when flush_i=1.
- mem_req_o  out  1  byte read request.
- mem_addr_o  out  16  read address; current fetch PC.
- mem_ready_i  in  1  request accepted when mem_req_o && mem_ready_i.
- mem_rvalid_i  in  1  read data valid; exactly one cycle after acceptance.
- mem_rdata_i  in  8  read data.
- instr_valid_o  out  1  bundle valid.
- instr_ready_i  in  1  decoder accepts bundle.
- instr_opcode_o  out  8  opcode byte; the second byte when CB-prefixed.
- instr_cb_o  out  1  CB-prefixed instruction.
- instr_imm_o  out  16  immediate; n8 in [7:0] with [15:8]=0; n16 little-endian.
- instr_len_o  out  2  instruction length in bytes (1–3).
- instr_pc_o  out  16  address of the first byte.

## Operation
- Fetch: mem_req_o=1 when no read is outstanding and queue count < QUEUE_DEPTH. The fetch PC increments on acceptance and wraps 0xFFFF→0x0000. mem_addr_o holds the fetch PC.
- Response: on mem_rvalid_i the byte and its address are written to the queue. The queue never overflows; the issue rule guarantees a free slot.
- Flush: the fetch PC loads redirect_pc_i. The queue, assembler state and instr_valid_o clear. A response returning the cycle after the flush is dropped (discard flag). A request may be issued in the flush cycle itself only if it uses the new PC; the implementation does not issue in the flush cycle. Flush has priority over every other event in the same cycle.
- Assembler FSM (decoder_state_t): READ_OPCODE, READ_CB_OPCODE, READ_R8, READ_R16_BYTE0, READ_R16_BYTE1. One byte is popped per cycle when the queue is non-empty.
  - READ_OPCODE: latch opcode and PC, then classify:
    - 0xCB → READ_CB_OPCODE.
    - n8 opcodes → READ_R8: 06 0E 16 1E 26 2E 36 3E, 18 20 28 30 38, C6 CE D6 DE E6 EE F6 FE, E0 F0 E8 F8.
    - n16 opcodes → READ_R16_BYTE0: 01 11 21 31 08, C2 C3 CA D2 DA, C4 CC CD D4 DC, EA FA.
    - Any other opcode, including illegal ones, completes with len 1.
  - READ_CB_OPCODE: the popped byte becomes the opcode, cb=1, len 2. Completes.
  - READ_R8: imm={8'h00,byte}, len 2. Completes.
  - READ_R16_BYTE0: imm[7:0]=byte → READ_R16_BYTE1.
  - READ_R16_BYTE1: imm[15:8]=byte, len 3. Completes.
  - After completion the FSM returns to READ_OPCODE.
- A completing pop is allowed only if instr_valid_o=0 or instr_ready_i=1 in that cycle. Non-completing pops are never blocked by the output.
- Output register: loaded on a completing pop and held stable while instr_valid_o && !instr_ready_i. Cleared on handshake unless reloaded in the same cycle.
- Reset values: mem_req_o=0; instr_valid_o=0; all output data 0; fetch PC=0x0000; FSM=READ_OPCODE; queue empty; discard flag clear.

## Timing
- A byte written on cycle N's edge is poppable on cycle N+1. A completing pop on cycle N gives instr_valid_o=1 on N+1.
- After flush at cycle t with memory always ready: request at t+1, rvalid at t+2, pop at t+3, instr_valid_o at t+4 for a 1-byte instruction.
- Steady-state throughput is one byte per 2 cycles (single outstanding read). Queue depth absorbs decoder back-pressure.
- Simultaneous queue push and pop in one cycle: count is unchanged.

## Structure
- gb_cpu_common_pkg: reuse decoder_state_t. Add typedef instr_bundle_t (opcode, cb, imm, len, pc), the function imm_len(opcode) returning 0/1/2, and the constant CB_PREFIX=8'hCB.
- Sub-module gb_cpu_byte_fifo: parametrised DEPTH and WIDTH=24 (byte plus PC), with push/pop, count, empty and full, and a synchronous clear.

## Test plan
- Reset, then flush to 0x0100; memory returns 00 C3 50 01. Expect bundles {op 00, len 1, pc 0100}, then {op C3, imm 0150, len 3, pc 0101}. First instr_valid_o exactly 4 cycles after flush.
- Bytes CB 37 3E 5A. Expect {op 37, cb 1, len 2}, then {op 3E, imm 005A, len 2}.
- Hold instr_ready_i=0 for 20 cycles. Queue fills to QUEUE_DEPTH, mem_req_o drops, and the output is stable. On release, all bundles arrive in order with none lost.
- Flush while READ_R16_BYTE0 and a read are in flight. The stale byte is dropped, and the next bundle has pc=redirect_pc_i.
- Fetch from 0xFFFF: mem_addr_o sequence FFFF, 0000. A 3-byte instruction at FFFE has pc FFFE and imm assembled from addresses FFFF and 0000.
- reset_n low for one cycle mid-instruction: all outputs return to reset values on the next edge, and fetch restarts at 0x0000.

Source files
------------

// File: rtl/gb_cpu_common_pkg.sv
// Shared types for the CPU front end.
//   decoder_state_t : byte-sequence state of the instruction assembler
//   instr_bundle_t  : one assembled instruction (opcode, cb, imm, len, pc)
//   imm_len()       : number of immediate bytes following an unprefixed opcode
//   CB_PREFIX       : prefix byte selecting the extended opcode page
package gb_cpu_common_pkg;

  typedef enum logic [2:0] {
    READ_OPCODE,
    READ_CB_OPCODE,
    READ_R8,
    READ_R16_BYTE0,
    READ_R16_BYTE1
  } decoder_state_t;

  localparam logic [7:0]  CB_PREFIX   = 8'hCB;
  // Queue entry: {byte address, byte}
  localparam int unsigned QUEUE_WIDTH = 24;

  typedef struct packed {
    logic [7:0]  opcode;
    logic        cb;
    logic [15:0] imm;
    logic [1:0]  len;
    logic [15:0] pc;
  } instr_bundle_t;

  // 0: no immediate, 1: n8, 2: n16 (little-endian). Illegal opcodes are 0.
  function automatic logic [1:0] imm_len(input logic [7:0] opcode);
    logic [1:0] n;
    n = 2'd0;
    case (opcode)
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
      8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'hE0, 8'hF0, 8'hE8, 8'hF8:
        n = 2'd1;
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
      8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
      8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC,
      8'hEA, 8'hFA:
        n = 2'd2;
      default:
        n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/gb_cpu_instr_assembler_if.sv
// Bus bundle of the instruction assembler.
//   mem_*   : byte read port towards the bus interface (single outstanding read,
//             response exactly one cycle after acceptance)
//   instr_* : assembled instruction towards the decoder (valid/ready)
// master = assembler side, slave = memory + decoder side.
interface gb_cpu_instr_assembler_if;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic        mem_ready_i;
  logic        mem_rvalid_i;
  logic [7:0]  mem_rdata_i;

  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [7:0]  instr_opcode_o;
  logic        instr_cb_o;
  logic [15:0] instr_imm_o;
  logic [1:0]  instr_len_o;
  logic [15:0] instr_pc_o;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_ready_i, mem_rvalid_i, mem_rdata_i,
    output instr_valid_o, instr_opcode_o, instr_cb_o, instr_imm_o,
           instr_len_o, instr_pc_o,
    input  instr_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_ready_i, mem_rvalid_i, mem_rdata_i,
    input  instr_valid_o, instr_opcode_o, instr_cb_o, instr_imm_o,
           instr_len_o, instr_pc_o,
    output instr_ready_i
  );
endinterface

// File: rtl/gb_cpu_byte_fifo.sv
// Circular FIFO holding prefetched bytes with their addresses.
//   clk, reset_n        : clock, synchronous active-low reset
//   clear_i             : synchronous clear (takes priority over push/pop)
//   push_i/push_data_i  : write one entry
//   pop_i/pop_data_o    : pop_data_o shows the head; pop_i consumes it
//   count_o/empty_o/full_o : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module gb_cpu_byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CNT_FULL);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o && !clear_i;
  assign do_push = push_i && (!full_o || do_pop) && !clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/gb_cpu_instr_assembler.sv
// Prefetching instruction-byte queue and operand assembler.
//   clk, reset_n   : clock, synchronous active-low reset
//   flush_i        : redirect; drops queue, partial instruction, output bundle
//                    and any response landing in the following cycle
//   redirect_pc_i  : new fetch PC, taken when flush_i=1
//   bus (master)   : mem_* byte read port and instr_* decoder handshake
// Fetch keeps at most one read outstanding and stops while the queue is full.
// The assembler pops one byte per cycle; only the byte that completes an
// instruction waits for the output register to be free.
module gb_cpu_instr_assembler
  import gb_cpu_common_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush_i,
  input  logic [15:0]             redirect_pc_i,
  gb_cpu_instr_assembler_if.master bus
);
  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_DEPTH = CW'(QUEUE_DEPTH);

  // Fetch side
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [15:0] inflight_pc_q, inflight_pc_d;
  logic        outstanding_q, outstanding_d;
  logic        discard_q, discard_d;
  logic        accept;

  // Queue
  logic                   fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [QUEUE_WIDTH-1:0] fifo_wdata, fifo_rdata;
  logic [CW-1:0]          fifo_count;
  logic [7:0]             pop_byte;
  logic [15:0]            pop_pc;

  // Assembler
  decoder_state_t state_q, state_d;
  logic [7:0]     asm_op_q, asm_op_d;
  logic [15:0]    asm_pc_q, asm_pc_d;
  logic [7:0]     asm_imm_lo_q, asm_imm_lo_d;
  instr_bundle_t  bundle_new;
  logic           completes;
  logic           out_free;

  // Output register
  logic           valid_q, valid_d;
  instr_bundle_t  out_q, out_d;

  // No issue in the flush cycle, so the old PC can never leak into a request.
  assign bus.mem_req_o  = reset_n && !flush_i && !outstanding_q &&
                          (fifo_count < CNT_DEPTH);
  assign bus.mem_addr_o = fetch_pc_q;
  assign accept         = bus.mem_req_o && bus.mem_ready_i;

  assign fifo_push  = bus.mem_rvalid_i && !discard_q && !flush_i;
  assign fifo_wdata = {inflight_pc_q, bus.mem_rdata_i};
  assign pop_byte   = fifo_rdata[7:0];
  assign pop_pc     = fifo_rdata[23:8];

  gb_cpu_byte_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (QUEUE_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (flush_i),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rdata),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    outstanding_d = accept || (outstanding_q && !bus.mem_rvalid_i);
    discard_d     = 1'b0;
    if (accept) begin
      fetch_pc_d    = fetch_pc_q + 16'd1;
      inflight_pc_d = fetch_pc_q;
    end
    if (flush_i) begin
      fetch_pc_d    = redirect_pc_i;
      outstanding_d = 1'b0;
      discard_d     = 1'b1;
    end
  end

  // Bundle that the head byte would complete in the current state.
  always_comb begin
    bundle_new = '0;
    completes  = 1'b0;
    case (state_q)
      READ_OPCODE: begin
        bundle_new.opcode = pop_byte;
        bundle_new.len    = 2'd1;
        bundle_new.pc     = pop_pc;
        completes         = (pop_byte != CB_PREFIX) && (imm_len(pop_byte) == 2'd0);
      end
      READ_CB_OPCODE: begin
        bundle_new.opcode = pop_byte;
        bundle_new.cb     = 1'b1;
        bundle_new.len    = 2'd2;
        bundle_new.pc     = asm_pc_q;
        completes         = 1'b1;
      end
      READ_R8: begin
        bundle_new.opcode = asm_op_q;
        bundle_new.imm    = {8'h00, pop_byte};
        bundle_new.len    = 2'd2;
        bundle_new.pc     = asm_pc_q;
        completes         = 1'b1;
      end
      READ_R16_BYTE1: begin
        bundle_new.opcode = asm_op_q;
        bundle_new.imm    = {pop_byte, asm_imm_lo_q};
        bundle_new.len    = 2'd3;
        bundle_new.pc     = asm_pc_q;
        completes         = 1'b1;
      end
      default: completes = 1'b0;
    endcase
  end

  assign out_free = !valid_q || bus.instr_ready_i;
  assign fifo_pop = !fifo_empty && !flush_i && (!completes || out_free);

  always_comb begin
    state_d      = state_q;
    asm_op_d     = asm_op_q;
    asm_pc_d     = asm_pc_q;
    asm_imm_lo_d = asm_imm_lo_q;
    if (fifo_pop) begin
      case (state_q)
        READ_OPCODE: begin
          asm_op_d = pop_byte;
          asm_pc_d = pop_pc;
          if (pop_byte == CB_PREFIX) begin
            state_d = READ_CB_OPCODE;
          end else begin
            case (imm_len(pop_byte))
              2'd1:    state_d = READ_R8;
              2'd2:    state_d = READ_R16_BYTE0;
              default: state_d = READ_OPCODE;
            endcase
          end
        end
        READ_R16_BYTE0: begin
          asm_imm_lo_d = pop_byte;
          state_d      = READ_R16_BYTE1;
        end
        default: state_d = READ_OPCODE;
      endcase
    end
    if (flush_i) state_d = READ_OPCODE;
  end

  always_comb begin
    valid_d = valid_q && !bus.instr_ready_i;
    out_d   = out_q;
    if (fifo_pop && completes) begin
      valid_d = 1'b1;
      out_d   = bundle_new;
    end
    if (flush_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc_q    <= '0;
      inflight_pc_q <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      state_q       <= READ_OPCODE;
      asm_op_q      <= '0;
      asm_pc_q      <= '0;
      asm_imm_lo_q  <= '0;
      valid_q       <= 1'b0;
      out_q         <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      state_q       <= state_d;
      asm_op_q      <= asm_op_d;
      asm_pc_q      <= asm_pc_d;
      asm_imm_lo_q  <= asm_imm_lo_d;
      valid_q       <= valid_d;
      out_q         <= out_d;
    end
  end

  // The issue rule reserves a slot for every accepted read.
  always_ff @(posedge clk) begin
    if (reset_n && fifo_push && !fifo_pop) assert (!fifo_full);
  end

  assign bus.instr_valid_o  = valid_q;
  assign bus.instr_opcode_o = out_q.opcode;
  assign bus.instr_cb_o     = out_q.cb;
  assign bus.instr_imm_o    = out_q.imm;
  assign bus.instr_len_o    = out_q.len;
  assign bus.instr_pc_o     = out_q.pc;

endmodule
